// File: rtl/ysyx_25030093_mdu_if.sv
// Request/response bus of the multiply/divide unit.
//   in_valid/in_ready   request handshake, with in_op (funct3), in_rs1, in_rs2, in_tag
//   out_valid/out_ready response handshake, with out_data and out_tag
// The master modport belongs to the execute stage that issues and consumes ops.
// The slave modport belongs to the unit.
interface ysyx_25030093_mdu_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/ysyx_25030093_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit.
// It accepts one op at a time. Multiplication uses a radix-2 shift-add
// datapath and division uses a restoring datapath. Each op takes XLEN busy
// cycles. A zero divisor or a signed overflow finishes in one cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   flush  synchronous cancel of the in-flight or unconsumed op
//   bus    slave side of ysyx_25030093_mdu_if (request/response handshakes)
// XLEN and TAG_W must match the parameters of the connected interface.
module ysyx_25030093_mdu #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    ysyx_25030093_mdu_if.slave    bus
);
    localparam int CNT_W = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         op_reg;
    logic               neg_reg;       // negate the product or the quotient
    logic               rem_neg_reg;   // the dividend was negative
    logic [XLEN-1:0]    hi_reg;        // product high half / partial remainder
    logic [XLEN-1:0]    lo_reg;        // multiplier, shifting out / dividend, shifting into quotient
    logic [XLEN-1:0]    b_reg;         // multiplicand magnitude / divisor magnitude
    logic [CNT_W-1:0]   cnt_reg;
    logic [XLEN-1:0]    out_data_reg;
    logic [TAG_W-1:0]   out_tag_reg;

    // Decode the request.
    logic               accept, is_div, a_signed, b_signed, a_neg, b_neg;
    logic               div_zero, div_ovf, special;
    logic [XLEN-1:0]    a_mag, b_mag, special_data;

    assign bus.in_ready  = (state_reg == IDLE) && !flush;
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_data  = out_data_reg;
    assign bus.out_tag   = out_tag_reg;

    assign accept   = bus.in_valid && bus.in_ready;
    assign is_div   = bus.in_op[2];
    // rs1 is signed for MULH, MULHSU, DIV and REM. rs2 is signed for MULH, DIV and REM.
    assign a_signed = (bus.in_op == 3'd1) || (bus.in_op == 3'd2) ||
                      (bus.in_op == 3'd4) || (bus.in_op == 3'd6);
    assign b_signed = (bus.in_op == 3'd1) || (bus.in_op == 3'd4) || (bus.in_op == 3'd6);
    assign a_neg    = a_signed && bus.in_rs1[XLEN-1];
    assign b_neg    = b_signed && bus.in_rs2[XLEN-1];
    assign a_mag    = a_neg ? -bus.in_rs1 : bus.in_rs1;
    assign b_mag    = b_neg ? -bus.in_rs2 : bus.in_rs2;

    assign div_zero = is_div && (bus.in_rs2 == '0);
    assign div_ovf  = is_div && !bus.in_op[0] &&
                      (bus.in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (bus.in_rs2 == {XLEN{1'b1}});
    assign special  = div_zero || div_ovf;
    // in_op[1] selects REM/REMU over DIV/DIVU.
    assign special_data = div_zero ? (bus.in_op[1] ? bus.in_rs1 : {XLEN{1'b1}})
                                   : (bus.in_op[1] ? {XLEN{1'b0}} : bus.in_rs1);

    // Multiply step. Add the multiplicand into the high half when the multiplier
    // LSB is set, then shift the whole product right. The carry out of the add
    // becomes the new MSB.
    logic [XLEN:0]      mul_sum;
    logic [XLEN-1:0]    mul_hi, mul_lo;
    assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});
    assign mul_hi  = mul_sum[XLEN:1];
    assign mul_lo  = {mul_sum[0], lo_reg[XLEN-1:1]};

    // Restoring-divide step. Shift the next dividend bit into the remainder and
    // subtract the divisor. Keep the difference when it is non-negative.
    logic [XLEN:0]      div_shift, div_diff;
    logic [XLEN-1:0]    div_hi, div_lo;
    assign div_shift = {hi_reg, lo_reg[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_reg};
    assign div_hi    = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    assign div_lo    = {lo_reg[XLEN-2:0], ~div_diff[XLEN]};

    // Fix up the signs. These use the step outputs, so the final BUSY cycle
    // registers the finished result directly.
    logic [2*XLEN-1:0]  prod, prod_fix;
    logic [XLEN-1:0]    mul_res, quo_fix, rem_fix, div_res, final_data;
    logic               last;
    assign prod       = {mul_hi, mul_lo};
    assign prod_fix   = neg_reg ? -prod : prod;
    assign mul_res    = (op_reg[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    assign quo_fix    = neg_reg ? -div_lo : div_lo;
    assign rem_fix    = rem_neg_reg ? -div_hi : div_hi;
    assign div_res    = op_reg[1] ? rem_fix : quo_fix;
    assign final_data = op_reg[2] ? div_res : mul_res;
    assign last       = (state_reg == BUSY) && (cnt_reg == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept) state_next = special ? DONE : BUSY;
                BUSY:    if (cnt_reg == CNT_W'(1)) state_next = DONE;
                DONE:    if (bus.out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg       <= '0;
            neg_reg      <= 1'b0;
            rem_neg_reg  <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            b_reg        <= '0;
            cnt_reg      <= '0;
            out_data_reg <= '0;
            out_tag_reg  <= '0;
        end else if (accept) begin
            op_reg      <= bus.in_op;
            neg_reg     <= a_neg ^ b_neg;
            rem_neg_reg <= a_neg;
            out_tag_reg <= bus.in_tag;
            hi_reg      <= '0;
            cnt_reg     <= CNT_W'(XLEN);
            // For a multiply, rs2 shifts through lo_reg as the multiplier.
            // For a divide, rs1 shifts through lo_reg as the dividend.
            lo_reg      <= is_div ? a_mag : b_mag;
            b_reg       <= is_div ? b_mag : a_mag;
            if (special) begin
                out_data_reg <= special_data;
            end
        end else if ((state_reg == BUSY) && !flush) begin
            hi_reg  <= op_reg[2] ? div_hi : mul_hi;
            lo_reg  <= op_reg[2] ? div_lo : mul_lo;
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (last) begin
                out_data_reg <= final_data;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25030093_mdu.sv
// Bench for ysyx_25030093_mdu. It instantiates one unit with XLEN=32 and one
// with XLEN=64 and drives them from a shared set of request variables. The
// variable sel picks which unit is active.
module tb_ysyx_25030093_mdu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_op = '0;
    logic [63:0] req_rs1 = '0;
    logic [63:0] req_rs2 = '0;
    logic [4:0]  req_tag = '0;
    logic        out_ready = 1'b0;

    logic        obs_in_ready, obs_valid;
    logic [63:0] obs_data;
    logic [4:0]  obs_tag;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_25030093_mdu_if #(.XLEN(32), .TAG_W(5)) if32 ();
    ysyx_25030093_mdu_if #(.XLEN(64), .TAG_W(5)) if64 ();

    assign if32.in_valid  = req_valid && !sel;
    assign if32.in_op     = req_op;
    assign if32.in_rs1    = req_rs1[31:0];
    assign if32.in_rs2    = req_rs2[31:0];
    assign if32.in_tag    = req_tag;
    assign if32.out_ready = out_ready && !sel;
    assign if64.in_valid  = req_valid && sel;
    assign if64.in_op     = req_op;
    assign if64.in_rs1    = req_rs1;
    assign if64.in_rs2    = req_rs2;
    assign if64.in_tag    = req_tag;
    assign if64.out_ready = out_ready && sel;

    assign obs_in_ready = sel ? if64.in_ready  : if32.in_ready;
    assign obs_valid    = sel ? if64.out_valid : if32.out_valid;
    assign obs_data     = sel ? if64.out_data  : {32'b0, if32.out_data};
    assign obs_tag      = sel ? if64.out_tag   : if32.out_tag;

    ysyx_25030093_mdu #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32.slave)
    );
    ysyx_25030093_mdu #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model built on 128-bit arithmetic.
    // SystemVerilog '/' truncates toward zero and the sign of '%' follows the
    // dividend. The model handles divide-by-zero explicitly. Signed overflow
    // yields +2^(xl-1), which masks down to rs1.
    function automatic logic [63:0] ref_mdu(input int xl, input logic [2:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub, r;
        logic [63:0] mask, am, bm;
        mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}};
        am = a & mask;
        bm = b & mask;
        if (xl == 32) begin
            sa = {{96{am[31]}}, am[31:0]};
            sb = {{96{bm[31]}}, bm[31:0]};
        end else begin
            sa = {{64{am[63]}}, am};
            sb = {{64{bm[63]}}, bm};
        end
        ua = {64'b0, am};
        ub = {64'b0, bm};
        case (op)
            3'd0: r = sa * sb;
            3'd1: r = (sa * sb) >>> xl;
            3'd2: r = (sa * ub) >>> xl;
            3'd3: r = (ua * ub) >>> xl;
            3'd4: r = (bm == 0) ? -128'sd1 : sa / sb;
            3'd5: r = (bm == 0) ? -128'sd1 : ua / ub;
            3'd6: r = (bm == 0) ? sa : sa % sb;
            default: r = (bm == 0) ? ua : ua % ub;
        endcase
        return r[63:0] & mask;
    endfunction

    function automatic bit is_special(input int xl, input logic [2:0] op,
                                      input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, most_neg;
        mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}};
        most_neg = (xl == 32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
        return op[2] && (((b & mask) == 0) ||
               (!op[0] && ((a & mask) == most_neg) && ((b & mask) == mask)));
    endfunction

    // One complete transaction: issue, wait for the result with a bounded wait,
    // hold out_ready low for 'hold' cycles, drain, then confirm the unit is idle.
    task automatic do_op(input logic s, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] tag,
                         input logic [63:0] exp, input int hold);
        int xl;
        int lat;
        int exp_lat;
        xl = s ? 64 : 32;
        exp_lat = is_special(xl, op, a, b) ? 1 : xl + 1;
        @(negedge clk);
        sel = s;
        req_op = op;
        req_rs1 = a;
        req_rs2 = b;
        req_tag = tag;
        req_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        check("issue_in_ready", {63'b0, obs_in_ready}, 64'd1);
        check("issue_out_valid", {63'b0, obs_valid}, 64'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!obs_valid && lat < 200);
        check("latency", 64'(lat), 64'(exp_lat));
        check("data", obs_data, exp);
        check("tag", {59'b0, obs_tag}, {59'b0, tag});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {63'b0, obs_valid}, 64'd1);
            check("hold_data", obs_data, exp);
            check("hold_tag", {59'b0, obs_tag}, {59'b0, tag});
            check("hold_in_ready", {63'b0, obs_in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("drain_valid", {63'b0, obs_valid}, 64'd0);
        check("drain_in_ready", {63'b0, obs_in_ready}, 64'd1);
        $display("op xlen=%0d funct3=%0d a=0x%0h b=0x%0h tag=%0d -> 0x%0h lat=%0d (exp 0x%0h lat %0d)",
                 xl, op, a, b, tag, obs_data, lat, exp, exp_lat);
    endtask

    function automatic logic [63:0] pick_operand(input int xl);
        logic [63:0] mask, v;
        mask = (xl == 32) ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}};
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = 64'd1;
            2: v = {64{1'b1}};
            3: v = (xl == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
            4: v = 64'($urandom_range(0, 20));
            default: v = {$urandom, $urandom};
        endcase
        return v & mask;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int guard;
        logic [2:0]  op;
        logic [63:0] a, b;
        logic        s;
        int          xl;

        // Check the reset state while rst_n is held low.
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            check("rst_out_valid", {63'b0, obs_valid}, 64'd0);
            check("rst_in_ready", {63'b0, obs_in_ready}, 64'd1);
            check("rst_out_data", obs_data, 64'd0);
            check("rst_out_tag", {59'b0, obs_tag}, 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed XLEN=32 cases.
        do_op(1'b0, 3'd0, 64'd7, 64'hFFFF_FFFD, 5'd3, 64'hFFFF_FFEB, 0);
        do_op(1'b0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd4, 64'hFFFF_FFFE, 0);
        do_op(1'b0, 3'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd5, 64'h0, 0);
        do_op(1'b0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd6, 64'hFFFF_FFFF, 0);
        do_op(1'b0, 3'd4, 64'hFFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFD, 0);
        do_op(1'b0, 3'd6, 64'hFFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF, 0);
        do_op(1'b0, 3'd5, 64'd100, 64'd7, 5'd9, 64'd14, 0);
        do_op(1'b0, 3'd7, 64'd100, 64'd7, 5'd10, 64'd2, 0);
        do_op(1'b0, 3'd5, 64'd5, 64'd0, 5'd11, 64'hFFFF_FFFF, 0);
        do_op(1'b0, 3'd6, 64'd5, 64'd0, 5'd12, 64'd5, 0);
        do_op(1'b0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 5'd13, 64'h8000_0000, 0);
        do_op(1'b0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 5'd14, 64'd0, 0);
        // Backpressure: out_ready held low for 5 cycles.
        do_op(1'b0, 3'd0, 64'd123, 64'd456, 5'd15, 64'd56088, 5);

        // Directed XLEN=64 cases.
        do_op(1'b1, 3'd0, 64'h1_0000_0000, 64'h1_0000_0000, 5'd16, 64'd0, 0);
        do_op(1'b1, 3'd3, 64'h1_0000_0000, 64'h1_0000_0000, 5'd17, 64'd1, 0);
        do_op(1'b1, 3'd4, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd18, 64'h8000_0000_0000_0000, 0);
        do_op(1'b1, 3'd5, 64'd5, 64'd0, 5'd19, {64{1'b1}}, 2);

        // Flush 10 cycles into a DIV. A request in the flush cycle is ignored.
        // The unit then accepts a MUL in the very next cycle.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            sel = k[0];
            req_op = 3'd4;
            req_rs1 = 64'd1000;
            req_rs2 = 64'd3;
            req_tag = 5'd20;
            req_valid = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            repeat (10) @(negedge clk);
            flush = 1'b1;
            req_op = 3'd7;
            req_tag = 5'd21;
            req_valid = 1'b1;
            #1;
            check("flush_in_ready", {63'b0, obs_in_ready}, 64'd0);
            @(posedge clk);
            #1 begin
                flush = 1'b0;
                req_valid = 1'b0;
            end
            do_op(k[0], 3'd0, 64'd11, 64'd13, 5'd22, 64'd143, 0);
        end

        // Pull rst_n low asynchronously mid-MUL.
        @(negedge clk);
        sel = 1'b0;
        req_op = 3'd0;
        req_rs1 = 64'd3;
        req_rs2 = 64'd5;
        req_tag = 5'd23;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy_valid", {63'b0, obs_valid}, 64'd0);
        check("arst_busy_data", obs_data, 64'd0);
        check("arst_busy_tag", {59'b0, obs_tag}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_release_in_ready", {63'b0, obs_in_ready}, 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (obs_valid) seen = 1'b1;
        end
        check("arst_no_stale", {63'b0, seen}, 64'd0);

        // Pull rst_n low asynchronously while a result waits in DONE.
        @(negedge clk);
        sel = 1'b1;
        req_op = 3'd0;
        req_rs1 = 64'd6;
        req_rs2 = 64'd7;
        req_tag = 5'd24;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!obs_valid && guard < 200);
        check("done_before_arst", obs_data, 64'd42);
        #2 rst_n = 1'b0;
        #1;
        check("arst_done_valid", {63'b0, obs_valid}, 64'd0);
        check("arst_done_data", obs_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_done_in_ready", {63'b0, obs_in_ready}, 64'd1);

        // Randomized ops against the reference model.
        for (int n = 0; n < 60; n++) begin
            s = 1'($urandom_range(0, 1));
            xl = s ? 64 : 32;
            op = 3'($urandom_range(0, 7));
            a = pick_operand(xl);
            b = pick_operand(xl);
            do_op(s, op, a, b, 5'($urandom_range(0, 31)), ref_mdu(xl, op, a, b),
                  $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_25030093_mdu.md
# ysyx_25030093_mdu

Iterative RV32M/RV64M multiply/divide unit sitting beside the single-cycle integer ALU in the execute stage. It accepts one operation at a time through a valid/ready handshake and computes all eight M-extension results with a radix-2 shift-add or restoring-divide datapath. The result and a pass-through destination tag are held until the consumer takes them. A synchronous flush cancels work on a mispredict or trap.

## Interface

- XLEN, 32, operand/result width; legal values 32 or 64
- TAG_W, 5, width of the opaque tag carried from request to response (normally rd index)
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous cancel of any in-flight or completed-but-unconsumed op
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- in_op  in  3  operation, equal to RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- in_rs1  in  XLEN  operand a (multiplicand / dividend)
- in_rs2  in  XLEN  operand b (multiplier / divisor)
- in_tag  in  TAG_W  tag returned with the result
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes the result this cycle
- out_data  out  XLEN  result
- out_tag  out  TAG_W  tag of the op producing out_data

## Operation

- States: IDLE, BUSY, DONE. Reset enters IDLE; out_data, out_tag, internal counter and accumulators reset to 0.
- in_ready = (state == IDLE) && !flush. out_valid = (state == DONE).
- Accept when in_valid && in_ready: latch op, tag, operand signs; convert signed operands to magnitudes (MULH: both signed; MULHSU: rs1 signed, rs2 unsigned; DIV/REM: both signed; others unsigned).
- Special cases, detected at accept, go IDLE -> DONE directly:
  - Divisor 0: DIV/DIVU -> all ones; REM/REMU -> rs1 unchanged.
  - Signed overflow (DIV/REM, rs1 = most negative, rs2 = all ones): DIV -> rs1; REM -> 0.
- Otherwise IDLE -> BUSY with counter = XLEN.
- BUSY multiply: 2*XLEN product register; each cycle conditionally add multiplicand and shift right one bit. MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits of the sign-corrected 2*XLEN product.
- BUSY divide: restoring; each cycle shift partial remainder left, trial-subtract divisor, set quotient bit on non-negative result.
- Counter decrements each BUSY cycle; the cycle it reaches 0, state -> DONE and out_data is registered after sign fix-up.
- Sign fix-up: product negated if the operand signs differ; quotient negated if dividend and divisor signs differ; remainder takes the dividend sign.
- DONE -> IDLE when out_ready. There is no accept in DONE, so back-to-back ops have one idle cycle between them.
- flush (any state) -> IDLE next edge. The result is discarded, out_valid falls, and in_valid in the flush cycle is ignored. flush has priority over out_ready and in_valid.
- out_data/out_tag stay stable while out_valid && !out_ready.

## Timing

- Normal op: accept at edge E0; BUSY edges E1..E_XLEN. out_valid is high from the cycle after E_XLEN: XLEN+1 cycles after the accept cycle (33 for XLEN=32).
- Special-case op: out_valid in the cycle after the accept edge (latency 1).
- Minimum issue interval: latency + 1 cycle when out_ready is held high.
- Async reset mid-BUSY or mid-DONE: all outputs deassert immediately and nothing completes after rst_n rises. in_ready is high in the first cycle after release.

## Test plan

- MUL 7 × 0xFFFFFFFD (XLEN=32) -> out_data 0xFFFFFFEB, tag echoed, out_valid exactly 33 cycles after accept. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH same -> 0x00000000; MULHSU same -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, both latency 1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- out_ready held low 5 cycles after out_valid: out_data/out_tag constant, in_ready low. Result consumed on the cycle out_ready rises; in_ready high the following cycle.
- flush 10 cycles into a DIV: no out_valid ever for that tag. A MUL accepted the cycle after flush completes correctly in 33 cycles. in_valid asserted during the flush cycle is not accepted.
- rst_n pulled low mid-MUL: out_valid and out_data go to 0 asynchronously, in_ready is high after release, and no stale result appears. Repeat the set with XLEN=64: MUL 2^32 × 2^32 -> low 0, MULHU -> 1.
